// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: derives PC and pipeline-register write
// enables, flushes and MEM/WB bubble from hazard, branch and data-memory
// handshake inputs, with a data-memory timeout watchdog and saturating
// performance counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_wr,
    output logic             IFID_wr,
    output logic             IDEX_wr,
    output logic             EXMEM_wr,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             MEMWB_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             timeout_err
);

    // Control vector: {PC_wr, IFID_wr, IDEX_wr, EXMEM_wr, IFID_flush, IDEX_flush, MEMWB_bubble}
    localparam logic [6:0] CtrlNormal = 7'b1111_000;
    localparam logic [6:0] CtrlMemStl = 7'b0000_001;
    localparam logic [6:0] CtrlBranch = 7'b1111_110;
    localparam logic [6:0] CtrlLdUse  = 7'b0011_010;
    localparam logic [6:0] CtrlReset  = 7'b0000_111;

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [6:0]       ctrl;
    logic [7:0]       wait_inc;

    // Branch flush beats load-use; memory stall is resolved by the caller.
    function automatic logic [6:0] cascade(input logic br, input logic hz);
        if (br) begin
            return CtrlBranch;
        end else if (hz) begin
            return CtrlLdUse;
        end
        return CtrlNormal;
    endfunction

    assign wait_inc = wait_q + 8'd1;

    // Next-state, wait counter and control-vector decode.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        ctrl    = CtrlNormal;
        unique case (state_q)
            StRun: begin
                if (mem_req && !mem_ready) begin
                    ctrl    = CtrlMemStl;
                    state_d = StMemWait;
                    // Entry cycle already counts as the first wait cycle.
                    wait_d  = 8'd1;
                end else begin
                    ctrl = cascade(branch_taken, hazard);
                end
            end
            StMemWait: begin
                if (!mem_ready) begin
                    ctrl   = CtrlMemStl;
                    wait_d = wait_inc;
                    if (wait_inc == TimeoutVal) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end else begin
                    ctrl    = cascade(branch_taken, hazard);
                    wait_d  = 8'd0;
                    state_d = StRun;
                end
            end
            StErr: begin
                ctrl = CtrlMemStl;
            end
            default: begin
                ctrl    = CtrlMemStl;
                state_d = StRun;
            end
        endcase
        if (!rst_n) begin
            ctrl = CtrlReset;
        end
    end

    assign {PC_wr, IFID_wr, IDEX_wr, EXMEM_wr, IFID_flush, IDEX_flush, MEMWB_bubble} = ctrl;

    // Saturating performance counters; frozen while reset is asserted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rst_n && !ctrl[6] && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (rst_n && ctrl[2] && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_q      <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

    localparam logic [6:0] NORM = 7'b1111_000;
    localparam logic [6:0] MSTL = 7'b0000_001;
    localparam logic [6:0] BRFL = 7'b1111_110;
    localparam logic [6:0] LDUS = 7'b0011_010;
    localparam logic [6:0] RSTV = 7'b0000_111;

    logic clk = 1'b0;
    logic rst_n, hazard, branch_taken, mem_req, mem_ready;
    logic pc_wr, ifid_wr, idex_wr, exmem_wr, ifid_flush, idex_flush, memwb_bubble;
    logic [15:0] stall_cnt, flush_cnt;
    logic timeout_err;
    logic pc_wr4, ifid_wr4, idex_wr4, exmem_wr4, ifid_flush4, idex_flush4, memwb_bubble4;
    logic [3:0] stall_cnt4, flush_cnt4;
    logic timeout_err4;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_wr(pc_wr), .IFID_wr(ifid_wr), .IDEX_wr(idex_wr), .EXMEM_wr(exmem_wr),
        .IFID_flush(ifid_flush), .IDEX_flush(idex_flush), .MEMWB_bubble(memwb_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .timeout_err(timeout_err)
    );

    pipe_ctrl #(.CNT_W(4), .TIMEOUT(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_wr(pc_wr4), .IFID_wr(ifid_wr4), .IDEX_wr(idex_wr4), .EXMEM_wr(exmem_wr4),
        .IFID_flush(ifid_flush4), .IDEX_flush(idex_flush4), .MEMWB_bubble(memwb_bubble4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .timeout_err(timeout_err4)
    );

    typedef struct {
        string      name;
        logic [6:0] outs;
        int         stall;
        int         flush;
        logic       err;
        int         stall4;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Monitor: outputs are combinational every cycle, compare mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, " ctrl"}, int'({pc_wr, ifid_wr, idex_wr, exmem_wr,
                                         ifid_flush, idex_flush, memwb_bubble}), int'(e.outs));
            chk({e.name, " stall_cnt"}, int'(stall_cnt), e.stall);
            chk({e.name, " flush_cnt"}, int'(flush_cnt), e.flush);
            chk({e.name, " timeout_err"}, int'(timeout_err), int'(e.err));
            chk({e.name, " stall_cnt4"}, int'(stall_cnt4), e.stall4);
        end
    end

    // Drive one cycle of inputs and queue the expected response for that cycle.
    // Counter expectations are the values registered by all previous edges.
    task automatic step(input string name, input logic r, input logic hz, input logic br,
                        input logic rq, input logic rd, input logic [6:0] eo,
                        input int es, input int ef, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; hazard = hz; branch_taken = br; mem_req = rq; mem_ready = rd;
        e.name = name; e.outs = eo; e.stall = es; e.flush = ef; e.err = ee;
        e.stall4 = (es > 15) ? 15 : es;
        sb_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        step("reset",      0, 0, 0, 0, 0, RSTV, 0, 0, 0);
        step("idle",       1, 0, 0, 0, 0, NORM, 0, 0, 0);
        step("loaduse",    1, 1, 0, 0, 0, LDUS, 0, 0, 0);
        step("after_lu",   1, 0, 0, 0, 0, NORM, 1, 0, 0);
        step("br_hz",      1, 1, 1, 0, 0, BRFL, 1, 0, 0);
        step("after_br",   1, 0, 0, 0, 0, NORM, 1, 1, 0);
        // Three-cycle memory wait then release.
        step("mw1",        1, 0, 0, 1, 0, MSTL, 1, 1, 0);
        step("mw2",        1, 0, 0, 1, 0, MSTL, 2, 1, 0);
        step("mw3",        1, 0, 0, 1, 0, MSTL, 3, 1, 0);
        step("mw_rel",     1, 0, 0, 1, 1, NORM, 4, 1, 0);
        step("mw_run",     1, 0, 0, 0, 0, NORM, 4, 1, 0);
        // MEMWAIT ignores mem_req while not ready; release applies cascade.
        step("mwa1",       1, 0, 0, 1, 0, MSTL, 4, 1, 0);
        step("mwa_noreq",  1, 0, 0, 0, 0, MSTL, 5, 1, 0);
        step("mwa_rel_lu", 1, 1, 0, 1, 1, LDUS, 6, 1, 0);
        step("mwa_idle",   1, 0, 0, 0, 0, NORM, 7, 1, 0);
        step("mwb1",       1, 0, 0, 1, 0, MSTL, 7, 1, 0);
        step("mwb_rel_br", 1, 1, 1, 1, 1, BRFL, 8, 1, 0);
        step("mwb_idle",   1, 0, 0, 0, 0, NORM, 8, 2, 0);
        // Reset in the middle of a memory wait.
        step("mwr1",       1, 0, 0, 1, 0, MSTL, 8, 2, 0);
        step("mwr_rst",    0, 0, 0, 1, 0, RSTV, 9, 2, 0);
        step("mwr_after",  1, 0, 0, 0, 0, NORM, 0, 0, 0);
        // Timeout: 16 unready cycles lead to ERR.
        for (int k = 1; k <= 16; k++) begin
            step($sformatf("to%0d", k), 1, 0, 0, 1, 0, MSTL, k - 1, 0, 0);
        end
        step("err_ready",  1, 0, 0, 1, 1, MSTL, 16, 0, 1);
        step("err_branch", 1, 0, 1, 0, 1, MSTL, 17, 0, 1);
        step("err_rst",    0, 0, 0, 0, 0, RSTV, 18, 0, 1);
        step("err_after",  1, 0, 0, 0, 0, NORM, 0, 0, 0);
        // 20 consecutive load-use stalls: 4-bit counter saturates at 15.
        for (int m = 1; m <= 20; m++) begin
            step($sformatf("sat%0d", m), 1, 1, 0, 0, 0, LDUS, m - 1, 0, 0);
        end
        step("sat_end",    1, 0, 0, 0, 0, NORM, 20, 0, 0);
        step("sat_hold",   1, 0, 0, 0, 0, NORM, 20, 0, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
